// File: rtl/uart_cap_pkg.sv
// Shared types and constants for the UART capture receiver.
package uart_cap_pkg;
   localparam int unsigned UART_MIN_DIV   = 4;
   localparam int unsigned UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_cap_state_e;
endpackage

// File: rtl/uart_cap_fifo.sv
// First-word-fall-through synchronous FIFO with registered head, valid and occupancy.
module uart_cap_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
   logic             empty, full, do_push, do_pop;

   assign empty   = (level == '0);
   assign full    = (level == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign do_push = push & (~full | do_pop);
   assign rd_nxt  = rd_ptr + AW'(1);
   assign valid   = ~empty;

   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         rdata    <= '0;
      end else if (clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         rdata    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_nxt;
         if (push && !do_push) overflow <= 1'b1;
         if (do_push && !do_pop)      level <= level + (AW+1)'(1);
         else if (do_pop && !do_push) level <= level - (AW+1)'(1);
         // Head register tracks the entry that will be at rd_ptr next cycle.
         if (do_pop)
            rdata <= (level == (AW+1)'(1)) ? wdata : mem[rd_nxt];
         else if (do_push && empty)
            rdata <= wdata;
      end
   end
endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: synchronizer, bit timer, framing FSM and shift register feeding a byte FIFO.
module uart_rx_capture
   import uart_cap_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DIV_W-1:0]              cfg_div_i,
   input  logic                          clr_i,
   input  logic                          rx_i,
   output logic [7:0]                    rx_data_o,
   output logic                          rx_valid_o,
   input  logic                          rx_ready_i,
   output logic                          frame_err_o,
   output logic                          overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          busy_o
);
   localparam int unsigned BW = $clog2(UART_DATA_BITS);

   uart_cap_state_e             state;
   logic [2:0]                  sync_q;
   logic                        rx_s, fall;
   logic [DIV_W-1:0]            div_eff, div_q, cnt;
   logic                        expire;
   logic [BW-1:0]               bit_cnt;
   logic [UART_DATA_BITS-1:0]   shreg;
   logic                        push;

   assign rx_s    = sync_q[1];
   assign fall    = sync_q[2] & ~sync_q[1];
   assign div_eff = (cfg_div_i < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : cfg_div_i;
   assign expire  = (cnt == '0);
   assign push    = (state == STOP) && expire && rx_s;
   assign busy_o  = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[1:0], rx_i};
   end

   // Counter holds cycles remaining, so reloads are one less than the interval.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         div_q       <= DIV_W'(UART_MIN_DIV);
         bit_cnt     <= '0;
         shreg       <= '0;
         frame_err_o <= 1'b0;
      end else begin
         frame_err_o <= 1'b0;
         if (!expire) cnt <= cnt - DIV_W'(1);
         case (state)
            IDLE: if (fall) begin
               div_q <= div_eff;
               cnt   <= (div_eff >> 1) - DIV_W'(1);
               state <= START;
            end
            START: if (expire) begin
               if (rx_s) state <= IDLE;
               else begin
                  cnt     <= div_q - DIV_W'(1);
                  bit_cnt <= '0;
                  state   <= DATA;
               end
            end
            DATA: if (expire) begin
               shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
               cnt     <= div_q - DIV_W'(1);
               bit_cnt <= bit_cnt + BW'(1);
               if (bit_cnt == BW'(UART_DATA_BITS-1)) state <= STOP;
            end
            STOP: if (expire) begin
               if (rx_s) state <= IDLE;
               else begin
                  frame_err_o <= 1'b1;
                  state       <= BREAK;
               end
            end
            BREAK: if (rx_s) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   uart_cap_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_i),
      .push     (push),
      .wdata    (shreg),
      .pop      (rx_ready_i),
      .rdata    (rx_data_o),
      .valid    (rx_valid_o),
      .level    (level_o),
      .overflow (overflow_o)
   );
endmodule

// File: tb/tb_uart_rx_capture.sv
// Scoreboard bench for uart_rx_capture: serial stimulus in, expected bytes queued and popped on output.
module tb_uart_rx_capture;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cfg_div_i = 16'd32;
   logic        clr_i = 1'b0;
   logic        rx_i = 1'b1;
   logic        rx_ready_i = 1'b0;
   logic [7:0]  rx_data_o;
   logic        rx_valid_o, frame_err_o, overflow_o, busy_o;
   logic [3:0]  level_o;

   int n_chk = 0;
   int n_err = 0;
   int err_cnt = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   uart_rx_capture #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
      .clk(clk), .rst(rst), .cfg_div_i(cfg_div_i), .clr_i(clr_i), .rx_i(rx_i),
      .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
      .frame_err_o(frame_err_o), .overflow_o(overflow_o), .level_o(level_o), .busy_o(busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Consumer side: every accepted pop is checked against the queue head.
   always @(negedge clk) begin
      if (!rst && rx_valid_o && rx_ready_i) begin
         if (exp_q.size() == 0) chk("sb_extra", 32'(exp_q.size()), 32'd1);
         else                   chk("sb_data", 32'(rx_data_o), 32'(exp_q.pop_front()));
      end
      if (frame_err_o) err_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input int bc, input logic stop);
      rx_i = 1'b0;
      tick(bc);
      for (int i = 0; i < 8; i++) begin
         rx_i = d[i];
         tick(bc);
      end
      rx_i = stop;
      tick(bc);
      rx_i = 1'b1;
   endtask

   task automatic drain();
      int n = 0;
      rx_ready_i = 1'b1;
      while (rx_valid_o && n < 100) begin
         tick(1);
         n++;
      end
      rx_ready_i = 1'b0;
      tick(1);
      chk("drain_q", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int e0;
      int cyc;
      logic [7:0] b;

      tick(3);
      chk("rst_valid", 32'(rx_valid_o), 32'd0);
      chk("rst_level", 32'(level_o), 32'd0);
      rst = 1'b0;
      tick(2);
      chk("init_data", 32'(rx_data_o), 32'd0);
      chk("init_ovf", 32'(overflow_o), 32'd0);
      chk("init_busy", 32'(busy_o), 32'd0);
      chk("init_ferr", 32'(frame_err_o), 32'd0);

      // Single byte with latency measurement
      e0 = err_cnt;
      exp_q.push_back(8'hA5);
      cyc = 0;
      fork
         send_byte(8'hA5, 32, 1'b1);
         while (!rx_valid_o && cyc < 400) begin
            tick(1);
            cyc++;
         end
      join
      chk("a5_latency", 32'(cyc), 32'(3 + 16 + 9 * 32));
      chk("a5_level", 32'(level_o), 32'd1);
      chk("a5_head", 32'(rx_data_o), 32'hA5);
      chk("a5_noerr", 32'(err_cnt - e0), 32'd0);
      drain();

      // Fill past depth: ninth byte dropped
      for (int i = 0; i < 9; i++) begin
         if (i < 8) exp_q.push_back(8'(i));
         send_byte(8'(i), 32, 1'b1);
      end
      tick(4);
      chk("fill_level", 32'(level_o), 32'd8);
      chk("fill_ovf", 32'(overflow_o), 32'd1);
      drain();
      chk("ovf_sticky", 32'(overflow_o), 32'd1);
      clr_i = 1'b1;
      tick(1);
      clr_i = 1'b0;
      chk("clr_ovf", 32'(overflow_o), 32'd0);

      // Full FIFO with pop in the push cycle
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(8'(8'h10 + i));
         send_byte(8'(8'h10 + i), 32, 1'b1);
      end
      exp_q.push_back(8'h18);
      fork
         send_byte(8'h18, 32, 1'b1);
         begin
            tick(306);
            rx_ready_i = 1'b1;
            tick(1);
            rx_ready_i = 1'b0;
            chk("fullpop_level", 32'(level_o), 32'd8);
            chk("fullpop_ovf", 32'(overflow_o), 32'd0);
         end
      join
      drain();

      // Short glitch is a false start
      e0 = err_cnt;
      rx_i = 1'b0;
      tick(10);
      rx_i = 1'b1;
      tick(40);
      chk("glitch_busy", 32'(busy_o), 32'd0);
      chk("glitch_level", 32'(level_o), 32'd0);
      chk("glitch_err", 32'(err_cnt - e0), 32'd0);

      // Bad stop bit
      e0 = err_cnt;
      send_byte(8'h3C, 32, 1'b0);
      tick(40);
      chk("ferr_pulse", 32'(err_cnt - e0), 32'd1);
      chk("ferr_level", 32'(level_o), 32'd0);
      chk("ferr_busy", 32'(busy_o), 32'd0);

      // Break: long low line
      e0 = err_cnt;
      rx_i = 1'b0;
      tick(40 * 32);
      chk("brk_busy", 32'(busy_o), 32'd1);
      chk("brk_pulse", 32'(err_cnt - e0), 32'd1);
      rx_i = 1'b1;
      tick(5);
      chk("brk_idle", 32'(busy_o), 32'd0);
      chk("brk_level", 32'(level_o), 32'd0);

      // Reset mid-frame discards partial byte and FIFO contents
      send_byte(8'h77, 32, 1'b1);
      tick(2);
      chk("pre_rst_level", 32'(level_o), 32'd1);
      fork
         send_byte(8'hFF, 32, 1'b1);
         begin
            tick(32 * 5 + 16);
            rst = 1'b1;
            tick(1);
            exp_q.delete();
            chk("mrst_valid", 32'(rx_valid_o), 32'd0);
            chk("mrst_data", 32'(rx_data_o), 32'd0);
            chk("mrst_level", 32'(level_o), 32'd0);
            chk("mrst_busy", 32'(busy_o), 32'd0);
            tick(2);
            rst = 1'b0;
         end
      join
      tick(20);
      exp_q.push_back(8'h11);
      send_byte(8'h11, 32, 1'b1);
      tick(2);
      chk("post_rst_level", 32'(level_o), 32'd1);
      drain();

      // Flush with three bytes queued
      for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i), 32, 1'b1);
      tick(2);
      chk("pre_clr_level", 32'(level_o), 32'd3);
      clr_i = 1'b1;
      tick(1);
      clr_i = 1'b0;
      chk("clr_level", 32'(level_o), 32'd0);
      chk("clr_valid", 32'(rx_valid_o), 32'd0);
      chk("clr_ovf2", 32'(overflow_o), 32'd0);

      // Divisor floor: 2 behaves as 4
      e0 = err_cnt;
      cfg_div_i = 16'd2;
      rx_ready_i = 1'b1;
      exp_q.push_back(8'h5A);
      send_byte(8'h5A, 4, 1'b1);
      tick(10);
      chk("floor_q", 32'(exp_q.size()), 32'd0);
      chk("floor_err", 32'(err_cnt - e0), 32'd0);

      // Fast line (31 cycles/bit) against div=32, back to back
      cfg_div_i = 16'd32;
      tick(10);
      e0 = err_cnt;
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         send_byte(b, 31, 1'b1);
      end
      tick(20);
      chk("fast_q", 32'(exp_q.size()), 32'd0);
      chk("fast_err", 32'(err_cnt - e0), 32'd0);
      chk("fast_ovf", 32'(overflow_o), 32'd0);
      rx_ready_i = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/uart_rx_capture.md
# uart_rx_capture

Synthesizable 8N1 UART receiver with output FIFO that consumes the serial stream leaving the chip's `uart_txp` pad and delivers bytes to on-bench checkers or an FPGA debug host. It sits directly downstream of the padded top-level UART transmitter. It replaces the behavioural bus model, so captured console output and exit strings can be checked in emulation as well as simulation.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: byte entries; must be a power of two, at least 2.
- `DIV_W`, 16: width of the baud divisor.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_div_i` in DIV_W: clock cycles per bit; values below 4 are treated as 4. Example: 32 for 781250 baud at 25 MHz.
- `clr_i` in 1: synchronous flush; empties the FIFO and clears `overflow_o`.
- `rx_i` in 1: serial line from the pad. Asynchronous; idles high.
- `rx_data_o` out 8: head-of-FIFO byte.
- `rx_valid_o` out 1: FIFO not empty.
- `rx_ready_i` in 1: consumer pops on `rx_valid_o & rx_ready_i`.
- `frame_err_o` out 1: one-cycle pulse when a stop bit is sampled low.
- `overflow_o` out 1: sticky; set when a byte is dropped because the FIFO is full.
- `level_o` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `busy_o` out 1: receive FSM is not in IDLE.

## Operation
- `rx_i` passes through a 2-flop synchronizer (reset value 1), then a third flop used for edge detection.
- FSM states:
  - IDLE: on a falling edge of the synced line, latch `div = max(cfg_div_i, 4)`, load the counter with `div/2` (floor), and go to START.
  - START: when the counter expires, sample the line. If it is 1, this is a false start: return to IDLE with no error. If it is 0, load the counter with `div` and go to DATA.
  - DATA: sample at each expiry, shifting the bit into the MSB of the shift register (LSB-first on the line). After 8 samples go to STOP.
  - STOP: sample at expiry.
    - If the stop bit is 1: push the byte and go to IDLE.
    - If the stop bit is 0: pulse `frame_err_o`, discard the byte, and go to BREAK.
  - BREAK: wait until the synced line is 1, then go to IDLE. This prevents a break condition from being decoded as repeated `8'h00` frames.
- Counter: a down-counter of DIV_W bits. Expiry is reaching 0, after which it reloads.
- Changing `cfg_div_i` mid-frame has no effect until the next start bit.
- FIFO: first-word-fall-through.
  - Push when full: the byte is dropped and `overflow_o` sets, unless a pop occurs in the same cycle, in which case the push is accepted and `level_o` is unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH. A separate count distinguishes full from empty.
- `clr_i` has priority over a same-cycle push or pop. Both are discarded.
- `clr_i` does not reset the FSM; a frame in progress completes and pushes normally.
- Reset values: `rx_data_o` = 0, `rx_valid_o` = 0, `frame_err_o` = 0, `overflow_o` = 0, `level_o` = 0, `busy_o` = 0, FSM in IDLE, synchronizer flops = 1.
- An asserted `rst` mid-frame discards the partial byte and the FIFO contents immediately.

## Timing
- Synchronizer plus edge detect delays the start edge by 3 cycles relative to `rx_i`. The same offset applies to all samples.
- START sample: `div/2` cycles after the edge is detected. Data bit n is sampled `div*(n+1)` cycles after the START sample. The stop bit is sampled at `9*div`.
- The byte is pushed in the cycle of the stop sample. `rx_valid_o` and `rx_data_o` are registered and update on the next edge (1-cycle latency).
- `frame_err_o` asserts on the cycle following the stop sample and lasts exactly 1 cycle.
- Back-to-back frames are supported: the FSM is in IDLE by the stop-bit midpoint, so the next start edge half a bit later is caught.
- Tolerated baud mismatch: ±4 % at `div` ≥ 16.

## Structure
- Shared package `uart_cap_pkg` holds:
  - the `uart_cap_state_e` enum (IDLE, START, DATA, STOP, BREAK);
  - `UART_MIN_DIV` = 4;
  - `UART_DATA_BITS` = 8.
- Sub-module `uart_cap_fifo`: a parameterised FWFT synchronous FIFO with registered outputs and an occupancy count. It is reusable by the planned SPI capture block.
- The top module contains the synchronizer, counter, FSM and shift register.

## Test plan
- **Single byte:** `cfg_div_i`=32, send 0xA5 → `rx_valid_o` rises 1 cycle after the stop sample with `rx_data_o`=0xA5, `level_o`=1; `frame_err_o` never pulses.
- **FIFO fill:** send 9 bytes 0x00..0x08 with `rx_ready_i`=0 and FIFO_DEPTH=8 → `level_o`=8 and `overflow_o`=1; the popped sequence is 0x00..0x07.
- **Glitch and framing error:**
  - A 10-cycle low glitch on `rx_i` → return to IDLE; no push, no error.
  - A frame 0x3C with stop bit 0 → one `frame_err_o` pulse, `level_o` stays 0.
  - Holding `rx_i` low for 40 bit-times → exactly one error pulse, and FSM in BREAK until the line returns high.
- **Full FIFO with simultaneous pop:** FIFO full while `rx_ready_i` is held 1 during the push cycle → byte accepted, `level_o` stays 8, `overflow_o` stays 0.
- **Reset and flush:**
  - Assert `rst` during bit 4 of 0xFF → outputs at reset values; the next clean 0x11 is received correctly.
  - `clr_i` with 3 bytes queued → `level_o`=0 and `overflow_o`=0 the next cycle.
- **Divisor floor and mismatch:**
  - `cfg_div_i`=2 → received as `div`=4; a 0x5A sent at 4 cycles/bit is captured.
  - Line at +3 % baud with `div`=32 → 16 random bytes received intact.
